// File: rtl/apb_master_ctrl.sv
// APB requester: takes single read/write commands on a valid/ready port and runs SETUP/ACCESS with pready waits.
// Optional build macro APB_TIMEOUT_EN aborts an ACCESS phase after TIMEOUT_CYCLES cycles without pready.
module apb_master_ctrl #(
   parameter int ADDR_WIDTH     = 8,
   parameter int DATA_WIDTH     = 91,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [DATA_WIDTH-1:0] cmd_wdata,
   output logic                  rsp_valid,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_error,
   output logic [ADDR_WIDTH-1:0] paddr,
   output logic                  pwrite,
   output logic                  psel,
   output logic                  penable,
   output logic [DATA_WIDTH-1:0] pwdata,
   input  logic [DATA_WIDTH-1:0] prdata,
   input  logic                  pready
);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

   state_t                  state_q, state_d;
   logic                    cmd_ready_d, rsp_valid_d, rsp_error_d;
   logic                    psel_d, penable_d, pwrite_d;
   logic [ADDR_WIDTH-1:0]   paddr_d;
   logic [DATA_WIDTH-1:0]   pwdata_d, rsp_rdata_d;

`ifdef APB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] wait_q, wait_d;
   logic          limit_hit;
   // wait_q counts earlier wait cycles, so the limit falls on ACCESS cycle number TIMEOUT_CYCLES
   assign limit_hit = (wait_q == CW'(TIMEOUT_CYCLES - 1));
`endif

   always_comb begin
      state_d     = state_q;
      cmd_ready_d = cmd_ready;
      rsp_valid_d = 1'b0;
      rsp_error_d = 1'b0;
      rsp_rdata_d = rsp_rdata;
      psel_d      = psel;
      penable_d   = penable;
      paddr_d     = paddr;
      pwrite_d    = pwrite;
      pwdata_d    = pwdata;
`ifdef APB_TIMEOUT_EN
      wait_d      = wait_q;
`endif
      case (state_q)
         IDLE: begin
            if (cmd_valid && cmd_ready) begin
               state_d     = SETUP;
               paddr_d     = cmd_addr;
               pwrite_d    = cmd_write;
               pwdata_d    = cmd_write ? cmd_wdata : '0;
               psel_d      = 1'b1;
               cmd_ready_d = 1'b0;
            end else begin
               // ready rises one cycle after reset release
               cmd_ready_d = 1'b1;
            end
         end
         SETUP: begin
            state_d   = ACCESS;
            penable_d = 1'b1;
`ifdef APB_TIMEOUT_EN
            wait_d    = '0;
`endif
         end
         ACCESS: begin
            if (pready) begin
               state_d     = IDLE;
               psel_d      = 1'b0;
               penable_d   = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_rdata_d = pwrite ? '0 : prdata;
               cmd_ready_d = 1'b1;
`ifdef APB_TIMEOUT_EN
            end else if (limit_hit) begin
               state_d     = IDLE;
               psel_d      = 1'b0;
               penable_d   = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_error_d = 1'b1;
               rsp_rdata_d = '0;
               cmd_ready_d = 1'b1;
            end else begin
               wait_d = wait_q + 1'b1;
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cmd_ready <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_error <= 1'b0;
         rsp_rdata <= '0;
         psel      <= 1'b0;
         penable   <= 1'b0;
         paddr     <= '0;
         pwrite    <= 1'b0;
         pwdata    <= '0;
      end else begin
         state_q   <= state_d;
         cmd_ready <= cmd_ready_d;
         rsp_valid <= rsp_valid_d;
         rsp_error <= rsp_error_d;
         rsp_rdata <= rsp_rdata_d;
         psel      <= psel_d;
         penable   <= penable_d;
         paddr     <= paddr_d;
         pwrite    <= pwrite_d;
         pwdata    <= pwdata_d;
      end
   end

`ifdef APB_TIMEOUT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) wait_q <= '0;
      else        wait_q <= wait_d;
   end
`endif

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Self-checking bench for apb_master_ctrl: vector table, reset/timeout sequences and random traffic vs. a transaction model.
module tb_apb_master_ctrl;
   localparam int AW = 8;
   localparam int DW = 91;
   localparam int TO = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          cmd_valid = 1'b0, cmd_write = 1'b0;
   logic [AW-1:0] cmd_addr = '0;
   logic [DW-1:0] cmd_wdata = '0, prdata = '0;
   logic          pready = 1'b0;
   logic          cmd_ready, rsp_valid, rsp_error, pwrite, psel, penable;
   logic [DW-1:0] rsp_rdata, pwdata;
   logic [AW-1:0] paddr;

   apb_master_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
      .paddr(paddr), .pwrite(pwrite), .psel(psel), .penable(penable),
      .pwdata(pwdata), .prdata(prdata), .pready(pready)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   logic [DW-1:0] last_rsp = '0;   // model: rsp_rdata holds the last response value

   function automatic void check1(string name, logic act, logic exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic void checkw(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic logic [DW-1:0] addr_w(logic [AW-1:0] a);
      return {{(DW-AW){1'b0}}, a};
   endfunction

   function automatic logic [DW-1:0] rand_data();
      logic [95:0] r;
      r = {$urandom(), $urandom(), $urandom()};
      return r[DW-1:0];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // protocol monitor: penable only with psel, and never in the first psel cycle
   logic psel_prev = 1'b0;
   always @(negedge clk) begin
      if (rst_n) begin
         check1("penable_without_psel", penable & ~psel, 1'b0);
         check1("penable_first_psel_cycle", penable & psel & ~psel_prev, 1'b0);
      end
      psel_prev = psel;
   end

   // One full transfer, starting in a cycle where cmd_ready is expected high.
   task automatic do_xfer(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                          input logic [DW-1:0] prd, input int waits, input logic [DW-1:0] exp_rdata);
      logic [DW-1:0] exp_pw;
      exp_pw = wr ? wdata : '0;
      check1("ready_before_accept", cmd_ready, 1'b1);
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
      pready = 1'($urandom_range(0, 1));
      tick();
      // scramble the command inputs: they must not matter once accepted
      cmd_valid = 1'($urandom_range(0, 1)); cmd_write = ~wr;
      cmd_addr = 8'($urandom()); cmd_wdata = rand_data();
      pready = 1'($urandom_range(0, 1));
      check1("setup_psel", psel, 1'b1);
      check1("setup_penable", penable, 1'b0);
      checkw("setup_paddr", addr_w(paddr), addr_w(addr));
      check1("setup_pwrite", pwrite, wr);
      checkw("setup_pwdata", pwdata, exp_pw);
      check1("setup_cmd_ready", cmd_ready, 1'b0);
      check1("setup_rsp_valid", rsp_valid, 1'b0);
      tick();
      cmd_valid = 1'b0;
      check1("access_psel", psel, 1'b1);
      check1("access_penable", penable, 1'b1);
      checkw("access_paddr", addr_w(paddr), addr_w(addr));
      for (int k = 0; k < waits; k++) begin
         pready = 1'b0; prdata = rand_data();
         tick();
         check1("wait_psel", psel, 1'b1);
         check1("wait_penable", penable, 1'b1);
         checkw("wait_paddr", addr_w(paddr), addr_w(addr));
         check1("wait_pwrite", pwrite, wr);
         checkw("wait_pwdata", pwdata, exp_pw);
         check1("wait_rsp_valid", rsp_valid, 1'b0);
      end
      pready = 1'b1; prdata = prd;
      tick();
      pready = 1'b0; prdata = rand_data();
      last_rsp = exp_rdata;
      check1("rsp_valid", rsp_valid, 1'b1);
      checkw("rsp_rdata", rsp_rdata, exp_rdata);
      check1("rsp_error", rsp_error, 1'b0);
      check1("rsp_psel_low", psel, 1'b0);
      check1("rsp_penable_low", penable, 1'b0);
      check1("rsp_cmd_ready", cmd_ready, 1'b1);
      checkw("rsp_paddr_hold", addr_w(paddr), addr_w(addr));
      checkw("rsp_pwdata_hold", pwdata, exp_pw);
   endtask

   task automatic idle_cycle();
      tick();
      check1("idle_rsp_valid", rsp_valid, 1'b0);
      check1("idle_rsp_error", rsp_error, 1'b0);
      checkw("idle_rsp_rdata_hold", rsp_rdata, last_rsp);
      check1("idle_psel", psel, 1'b0);
      check1("idle_cmd_ready", cmd_ready, 1'b1);
   endtask

   typedef struct {
      logic          wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [DW-1:0] prd;
      int            waits;
      logic [DW-1:0] exp_rdata;
   } vec_t;

   vec_t vecs[6];

   initial begin
      vecs[0] = '{1'b1, 8'd1,   91'd6, 91'h55,  0, 91'd0};
      vecs[1] = '{1'b0, 8'd11,  91'd9, 91'd7,   0, 91'd7};
      vecs[2] = '{1'b1, 8'd1,   91'd3, 91'h77,  4, 91'd0};
      vecs[3] = '{1'b1, 8'd1,   91'd1, 91'h99,  0, 91'd0};
      vecs[4] = '{1'b0, 8'd0,   91'd5, 91'h1234_5678_9abc, 0, 91'h1234_5678_9abc};
      vecs[5] = '{1'b0, 8'hFF,  91'd0, {DW{1'b1}}, 2, {DW{1'b1}}};

      // reset state
      tick(); tick();
      check1("reset_cmd_ready", cmd_ready, 1'b0);
      check1("reset_psel", psel, 1'b0);
      check1("reset_penable", penable, 1'b0);
      check1("reset_rsp_valid", rsp_valid, 1'b0);
      checkw("reset_rsp_rdata", rsp_rdata, '0);
      checkw("reset_paddr", addr_w(paddr), '0);
      checkw("reset_pwdata", pwdata, '0);
      rst_n = 1'b1;
      cmd_valid = 1'b1;   // must not be accepted while ready is still low
      check1("release_cmd_ready", cmd_ready, 1'b0);
      tick();
      cmd_valid = 1'b0;
      check1("release2_cmd_ready", cmd_ready, 1'b1);
      check1("release2_psel", psel, 1'b0);

      // table vectors, issued back-to-back
      for (int i = 0; i < 6; i++)
         do_xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].prd, vecs[i].waits, vecs[i].exp_rdata);
      idle_cycle();
      idle_cycle();

      // reset during ACCESS of a read
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h22;
      tick();
      cmd_valid = 1'b0;
      tick();
      check1("pre_reset_penable", penable, 1'b1);
      #3;
      rst_n = 1'b0;
      #1;
      check1("async_psel", psel, 1'b0);
      check1("async_penable", penable, 1'b0);
      check1("async_rsp_valid", rsp_valid, 1'b0);
      check1("async_cmd_ready", cmd_ready, 1'b0);
      pready = 1'b1; prdata = rand_data();
      tick(); tick();
      rst_n = 1'b1;
      check1("rel_cmd_ready_first", cmd_ready, 1'b0);
      tick();
      check1("rel_cmd_ready_second", cmd_ready, 1'b1);
      check1("rel_no_spurious_rsp", rsp_valid, 1'b0);
      check1("rel_psel", psel, 1'b0);
      pready = 1'b0;
      last_rsp = '0;
      idle_cycle();

`ifdef APB_TIMEOUT_EN
      // pready stuck low: abort on ACCESS cycle TO
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h05;
      tick();
      cmd_valid = 1'b0;
      tick();
      for (int k = 1; k < TO; k++) begin
         pready = 1'b0;
         tick();
         check1("to_wait_penable", penable, 1'b1);
         check1("to_wait_rsp_valid", rsp_valid, 1'b0);
      end
      tick();
      last_rsp = '0;
      check1("to_rsp_valid", rsp_valid, 1'b1);
      check1("to_rsp_error", rsp_error, 1'b1);
      checkw("to_rsp_rdata", rsp_rdata, '0);
      check1("to_psel", psel, 1'b0);
      check1("to_cmd_ready", cmd_ready, 1'b1);
      idle_cycle();
      // pready rises on the limit cycle: normal completion
      do_xfer(1'b0, 8'h06, '0, 91'h4242, TO - 1, 91'h4242);
      idle_cycle();
`endif

      // random traffic against the transaction model
      for (int i = 0; i < 40; i++) begin
         logic          wr;
         logic [DW-1:0] wd, pd;
         wr = 1'($urandom_range(0, 1));
         wd = rand_data();
         pd = rand_data();
         do_xfer(wr, 8'($urandom()), wd, pd, int'($urandom_range(0, 5)), wr ? '0 : pd);
         for (int g = int'($urandom_range(0, 2)); g > 0; g--) idle_cycle();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

endmodule
